sdiv8_seq: RTL and testbench



---
 rtl/div_pkg.sv | 8 +
 rtl/div_step.sv | 20 ++
 rtl/sdiv8_seq.sv | 88 ++++++++
 tb/tb_sdiv8_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the signed divider.
package div_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step; q_n[0] is the new quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] qin,
    input  logic [WIDTH-1:0] dm,
    output logic [WIDTH:0]   acc_n,
    output logic [WIDTH-1:0] q_n
);
    logic [WIDTH+1:0] sh, diff;
    always_comb begin
        sh    = {acc, qin[WIDTH-1]};
        diff  = sh - {2'b00, dm};
        acc_n = diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0];
        q_n   = {qin[WIDTH-2:0], ~diff[WIDTH+1]};
    end
endmodule

// File: rtl/sdiv8_seq.sv
// sdiv8_seq: sequential signed radix-2 restoring divider with truncating quotient and dividend-signed remainder.
module sdiv8_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] dx,
    input  logic [WIDTH-1:0] dy,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] dx2,
    output logic [WIDTH-1:0] dy2,
    output logic             div_zero,
    output logic             ovf
);
    localparam int CW = cnt_width(WIDTH);
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] acc, acc_n;
    logic [WIDTH-1:0] qs, qs_n, dm, rx, ry;
    logic sx, sy;
    assign in_ready = (state == S_IDLE);
    div_step #(.WIDTH(WIDTH)) u_step (
        .acc  (acc),
        .qin  (qs),
        .dm   (dm),
        .acc_n(acc_n),
        .q_n  (qs_n)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            qs        <= '0;
            dm        <= '0;
            rx        <= '0;
            ry        <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dx2       <= '0;
            dy2       <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_CALC;
                    cnt   <= CW'(WIDTH - 1);
                    acc   <= '0;
                    qs    <= dx[WIDTH-1] ? -dx : dx;
                    dm    <= dy[WIDTH-1] ? -dy : dy;
                    sx    <= dx[WIDTH-1];
                    sy    <= dy[WIDTH-1];
                    rx    <= dx;
                    ry    <= dy;
                end
                S_CALC: begin
                    acc <= acc_n;
                    qs  <= qs_n;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    // A zero divisor leaves all-ones/|dx| in the datapath; force the defined result instead.
                    quotient  <= (ry == '0) ? '1 : ((sx ^ sy) ? -qs : qs);
                    remainder <= (ry == '0) ? rx : WIDTH'(sx ? -acc : acc);
                    dx2       <= rx;
                    dy2       <= ry;
                    div_zero  <= (ry == '0);
                    ovf       <= (rx == {1'b1, {(WIDTH-1){1'b0}}}) && (ry == '1);
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdiv8_seq.sv
// tb_sdiv8_seq: per-cycle comparison of sdiv8_seq against an edge-counting arithmetic model, plus literal pins.
module tb_sdiv8_seq;
    localparam int W = 8;
    logic CLK = 1'b0, RST = 1'b1, start = 1'b0;
    logic [W-1:0] dx = '0, dy = '0;
    logic in_ready, out_valid, div_zero, ovf;
    logic [W-1:0] quotient, remainder, dx2, dy2;

    sdiv8_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .dx(dx), .dy(dy),
        .in_ready(in_ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder),
        .dx2(dx2), .dy2(dy2), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    int vectors = 0, miscompares = 0;
    int edge_n = 0, free_at = 0, pend_edge = 0;
    logic pend = 1'b0, exp_ov = 1'b0;
    logic [W-1:0] pq, pr, pdx, pdy, hq = '0, hr = '0, hdx = '0, hdy = '0;
    logic pz, po, hz = 1'b0, ho = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", n, a, e, edge_n);
        end
    endtask

    // Model: a result accepted at edge N appears after edge N+W+1; the next start is taken from edge N+W+2.
    task automatic tick();
        int a, b, qi, ri, xi, yi;
        @(posedge CLK);
        edge_n++;
        exp_ov = 1'b0;
        if (RST) begin
            pend = 1'b0;
            free_at = edge_n + 1;
            {hq, hr, hdx, hdy} = '0;
            hz = 1'b0;
            ho = 1'b0;
        end else begin
            if (pend && pend_edge == edge_n) begin
                {hq, hr, hdx, hdy, hz, ho} = {pq, pr, pdx, pdy, pz, po};
                exp_ov = 1'b1;
                pend = 1'b0;
            end
            if (start && edge_n >= free_at) begin
                a = $signed(dx);
                b = $signed(dy);
                pdx = dx;
                pdy = dy;
                pz = (b == 0);
                po = (a == -(1 << (W - 1))) && (b == -1);
                pq = pz ? '1 : W'(a / b);
                pr = pz ? dx : W'(a % b);
                pend = 1'b1;
                pend_edge = edge_n + W + 1;
                free_at = pend_edge + 1;
            end
        end
        @(negedge CLK);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, edge_n + 1 >= free_at);
        chk("quotient", quotient, hq);
        chk("remainder", remainder, hr);
        chk("dx2", dx2, hdx);
        chk("dy2", dy2, hdy);
        chk("div_zero", div_zero, hz);
        chk("ovf", ovf, ho);
        if (out_valid && !div_zero && !ovf) begin
            qi = $signed(quotient);
            ri = $signed(remainder);
            xi = $signed(dx2);
            yi = $signed(dy2);
            chk("identity", qi * yi + ri, xi);
            chk("rem_mag", ((ri < 0) ? -ri : ri) < ((yi < 0) ? -yi : yi), 1);
            chk("rem_sign", (ri == 0) || ((ri < 0) == (xi < 0)), 1);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] eq,
                      input logic [W-1:0] er, input logic ez, input logic eo);
        int n;
        dx = x;
        dy = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        chk("latency", n + 1, W + 2);
        chk("lit_q", quotient, eq);
        chk("lit_r", remainder, er);
        chk("lit_dx2", dx2, x);
        chk("lit_dy2", dy2, y);
        chk("lit_dz", div_zero, ez);
        chk("lit_ovf", ovf, eo);
    endtask

    logic [W-1:0] corners [7] = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h02, 8'hFE};

    initial begin
        int n;
        repeat (2) tick();
        RST = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_q", quotient, 0);
        op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        op(-8'd100, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
        op(8'd100, -8'd7, 8'hF2, 8'h02, 1'b0, 1'b0);
        op(-8'd100, -8'd7, 8'h0E, 8'hFE, 1'b0, 1'b0);
        op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        op(8'd127, 8'hFF, 8'h81, 8'h00, 1'b0, 1'b0);
        op(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1'b0);
        op(-8'd5, 8'd0, 8'hFF, 8'hFB, 1'b1, 1'b0);
        repeat (3) tick();
        dx = 8'd50;
        dy = 8'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        dx = 8'd1;
        dy = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        chk("ign_q", quotient, 8'd8);
        chk("ign_r", remainder, 8'd2);
        chk("ign_dx2", dx2, 8'd50);
        repeat (12) tick();
        dx = 8'd100;
        dy = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_dx2", dx2, 0);
        repeat (12) tick();
        op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
        foreach (corners[i]) foreach (corners[j]) begin
            dx = corners[i];
            dy = corners[j];
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (W + 1) tick();
        end
        repeat (6000) begin
            start = ($urandom_range(0, 2) != 0);
            dx = W'($urandom);
            dy = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 6)] : W'($urandom);
            RST = ($urandom_range(0, 499) == 0);
            tick();
        end
        RST = 1'b0;
        start = 1'b0;
        repeat (W + 3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
